// File: rtl/timebase_ctrl.sv
// timebase_ctrl: run/pause/clear controller for the system timebase.
//
// A prescaler divides clk by SYS_DIV into tick_us; two decimal stages divide
// by DEC_DIV into tick_ms and tick_s; sec_cnt counts seconds 0..59. All ticks
// are single-cycle clock enables, registered, and only advance while RUN.
//
// Ports:
//   clk      in   system clock, posedge
//   reset_n  in   asynchronous active-low reset
//   start    in   run / resume request (level)
//   stop     in   pause request (level)
//   clear    in   return to IDLE and zero all counts (level)
//   state    out  2'b00 IDLE, 2'b01 RUN, 2'b10 PAUSE
//   busy     out  high while RUN
//   tick_us  out  one pulse every SYS_DIV running cycles
//   tick_ms  out  one pulse every DEC_DIV tick_us periods
//   tick_s   out  one pulse every DEC_DIV tick_ms periods
//   sec_cnt  out  seconds count 0..59
//
// Build option: define TIMEBASE_FAST_SIM_EN to force SYS_DIV=4 and DEC_DIV=10
// regardless of the parameters (fast simulation); port list is unchanged.
module timebase_ctrl #(
  parameter int unsigned SYS_DIV = 100,
  parameter int unsigned DEC_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [1:0] state,
  output logic       busy,
  output logic       tick_us,
  output logic       tick_ms,
  output logic       tick_s,
  output logic [5:0] sec_cnt
);

`ifdef TIMEBASE_FAST_SIM_EN
  localparam int unsigned SYS_DIV_E = 4;
  localparam int unsigned DEC_DIV_E = 10;
`else
  localparam int unsigned SYS_DIV_E = SYS_DIV;
  localparam int unsigned DEC_DIV_E = DEC_DIV;
`endif

  localparam int unsigned SYS_W = (SYS_DIV_E > 1) ? $clog2(SYS_DIV_E) : 1;
  localparam int unsigned DEC_W = (DEC_DIV_E > 1) ? $clog2(DEC_DIV_E) : 1;

  localparam logic [SYS_W-1:0] SYS_MAX = SYS_W'(SYS_DIV_E - 1);
  localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(DEC_DIV_E - 1);
  localparam logic [5:0]       SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [SYS_W-1:0] cnt_sys_q, cnt_sys_d;
  logic [DEC_W-1:0] cnt_us_q, cnt_us_d;
  logic [DEC_W-1:0] cnt_ms_q, cnt_ms_d;
  logic [5:0]       sec_q, sec_d;
  logic             tick_us_q, tick_us_d;
  logic             tick_ms_q, tick_ms_d;
  logic             tick_s_q, tick_s_d;
  logic             run_en;

  // Priority clear > stop > start; stop outside RUN is a no-op that still
  // masks a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if (state_q != ST_RUN) state_d = ST_RUN;
    end
    busy_d = (state_d == ST_RUN);
  end

  // Count only on edges where we are in RUN and stay in RUN, so the stop
  // edge neither advances the counters nor emits a tick.
  assign run_en = (state_q == ST_RUN) && !clear && !stop;

  always_comb begin
    cnt_sys_d = cnt_sys_q;
    cnt_us_d  = cnt_us_q;
    cnt_ms_d  = cnt_ms_q;
    sec_d     = sec_q;
    tick_us_d = 1'b0;
    tick_ms_d = 1'b0;
    tick_s_d  = 1'b0;
    if (clear) begin
      cnt_sys_d = '0;
      cnt_us_d  = '0;
      cnt_ms_d  = '0;
      sec_d     = '0;
    end else if (run_en) begin
      cnt_sys_d = (cnt_sys_q == SYS_MAX) ? '0 : cnt_sys_q + SYS_W'(1);
      if (cnt_sys_q == SYS_MAX) begin
        tick_us_d = 1'b1;
        cnt_us_d  = (cnt_us_q == DEC_MAX) ? '0 : cnt_us_q + DEC_W'(1);
        if (cnt_us_q == DEC_MAX) begin
          tick_ms_d = 1'b1;
          cnt_ms_d  = (cnt_ms_q == DEC_MAX) ? '0 : cnt_ms_q + DEC_W'(1);
          if (cnt_ms_q == DEC_MAX) begin
            tick_s_d = 1'b1;
            sec_d    = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      cnt_sys_q <= '0;
      cnt_us_q  <= '0;
      cnt_ms_q  <= '0;
      sec_q     <= '0;
      tick_us_q <= 1'b0;
      tick_ms_q <= 1'b0;
      tick_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_sys_q <= cnt_sys_d;
      cnt_us_q  <= cnt_us_d;
      cnt_ms_q  <= cnt_ms_d;
      sec_q     <= sec_d;
      tick_us_q <= tick_us_d;
      tick_ms_q <= tick_ms_d;
      tick_s_q  <= tick_s_d;
    end
  end

  assign state   = state_q;
  assign busy    = busy_q;
  assign tick_us = tick_us_q;
  assign tick_ms = tick_ms_q;
  assign tick_s  = tick_s_q;
  assign sec_cnt = sec_q;

endmodule

// File: doc/timebase_ctrl.md
Name: timebase_ctrl

Overview:
- Run/pause/clear controller that sequences the system timebase.
- Cascades a system-clock prescaler with two decimal divider stages, producing single-cycle tick enables for µs, ms and s, plus a 0–59 seconds count.
- Sits between `clk` and the stopwatch/clock display logic. Downstream blocks use its ticks as clock enables instead of derived clocks.

Parameters:
- SYS_DIV, 100, `clk` cycles per `tick_us` (≥2).
- DEC_DIV, 1000, `tick_us` per `tick_ms` and `tick_ms` per `tick_s` (≥2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  level, sampled each edge; run/resume request.
- stop  input  1  level; pause request.
- clear  input  1  level; return to IDLE and zero all counts.
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE (11 never driven).
- busy  output  1  high when state is RUN.
- tick_us  output  1  one-cycle pulse every SYS_DIV running cycles.
- tick_ms  output  1  one-cycle pulse every DEC_DIV `tick_us` periods.
- tick_s  output  1  one-cycle pulse every DEC_DIV `tick_ms` periods.
- sec_cnt  output  6  seconds count, 0..59.

Behaviour:
- Reset (reset_n low, async): state=IDLE; internal counters cnt_sys, cnt_us, cnt_ms = 0; sec_cnt=0; all ticks 0; busy=0.
- Counter widths: $clog2(SYS_DIV) and $clog2(DEC_DIV), minimum 1.
- Command priority each edge: clear > stop > start.
- FSM transitions:
  - IDLE: start → RUN. stop is ignored.
  - RUN: stop → PAUSE. start is ignored.
  - PAUSE: start → RUN (resume, counts preserved).
  - Any state: clear → IDLE, all counters and sec_cnt zeroed, ticks forced 0 on the next cycle.
  - start and stop together in RUN → PAUSE. In IDLE or PAUSE → no change (stop wins, stop is no-op).
- Counting occurs only on edges where state is already RUN. The transition edge itself does not count.
- Prescaler: cnt_sys increments. At SYS_DIV-1 it wraps to 0, and `tick_us` registers high for exactly the following cycle.
- First `tick_us` after start accepted at edge k is high in the cycle after edge k+SYS_DIV.
- µs stage: on the wrap edge of cnt_sys, cnt_us increments. At DEC_DIV-1 it wraps to 0 and `tick_ms` registers high in the same cycle as that `tick_us`.
- ms stage: on the edge where both cnt_sys and cnt_us wrap, cnt_ms increments. At DEC_DIV-1 it wraps and `tick_s` registers high, coincident with `tick_us` and `tick_ms`.
- Seconds: on the `tick_s` edge, sec_cnt increments, 59 → 0. The update is visible in the same cycle `tick_s` is high.
- PAUSE: all counters hold; ticks are 0. A tick that would fire on the stop edge is suppressed.
- On resume, counting continues from the held values, so no partial period is lost or repeated.
- `busy` and `state` are registered and change in the cycle after the accepting edge.
- Async reset mid-RUN: immediate return to reset values; no tick is emitted.

Optional Feature:
- Macro: TIMEBASE_FAST_SIM_EN.
- Defined: effective SYS_DIV=4 and DEC_DIV=10, regardless of parameters. sec_cnt still wraps at 59. Intended for simulation and fast bench runs.
- Undefined: parameters are used as given.
- Port list is identical in both builds.

Test Plan (SYS_DIV=4, DEC_DIV=5, macro undefined):
- Reset, then start pulse at edge 0 → state=01 and busy=1 from cycle 1. `tick_us` high in cycles 5, 9, 13, …; each pulse exactly 1 cycle wide.
- Run 100 cycles from start → `tick_ms` coincident with every 5th `tick_us` (first at cycle 21). First `tick_s` at cycle 101, with sec_cnt going 0→1 in that cycle.
- stop asserted for 1 cycle at edge 7, 30 idle cycles, then start → no ticks during PAUSE. Next `tick_us` arrives 2 running cycles after resume (cnt_sys held at 2).
- start and stop held together while in RUN → PAUSE. Both held in IDLE → stays IDLE, busy=0.
- clear asserted with start and stop while in RUN at sec_cnt=3 → next cycle state=00, sec_cnt=0, all ticks 0.
- Run 60×100 cycles → sec_cnt wraps 59→0 on the 60th `tick_s`. reset_n pulsed low mid-period → outputs are zero asynchronously, before the next edge.
